// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced through a single 4-bit ripple slice,
// one nibble per clock, LSB nibble first, with carry and signed-overflow flags.

module nibble_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             done_q, done_d, busy_q, busy_d;
    logic [3:0]       slice_a, slice_b, slice_s;
    logic             slice_co;

    assign slice_a = a_q[{k_q, 2'b00} +: 4];
    assign slice_b = b_q[{k_q, 2'b00} +: 4];

    nibble_adder4 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        k_d     = k_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b once here, carry-in = sub.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Nibbles shift in from the top so the result lands aligned after N steps.
                res_d   = {slice_s, res_q[WIDTH-1:4]};
                carry_d = slice_co;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = slice_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
